// File: rtl/pixel_binarizer_pkg.sv
// pixel_binarizer_pkg: shared video types and geometry for the binarizer and ROI stages.
package pixel_binarizer_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;
  localparam int WIDTH_DEF  = 640;
  localparam int HEIGHT_DEF = 480;
  localparam int X_W = 10;
  localparam int Y_W = 9;
endpackage

// File: rtl/pixel_binarizer.sv
// pixel_binarizer: thresholds a camera gray stream into ink pixels with x/y position and line/frame pulses.
module pixel_binarizer
  import pixel_binarizer_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int HEIGHT   = HEIGHT_DEF,
  parameter bit INK_DARK = 1'b1
) (
  input  logic           iCLK,
  input  logic           iRST,
  input  logic [7:0]     iGray,
  input  logic           iDVAL,
  input  logic           iFVAL,
  input  logic [7:0]     iThresh,
  input  logic           iErr_clr,
  output logic           oPixel,
  output logic           oPix_val,
  output logic [X_W-1:0] oX,
  output logic [Y_W-1:0] oY,
  output logic           oRow_end,
  output logic           oFrame_end,
  output logic [1:0]     oErr
);
  localparam logic [X_W-1:0] XLIM = X_W'(WIDTH);
  localparam logic [Y_W-1:0] YLIM = Y_W'(HEIGHT);
  state_t state_q, state_d;
  logic [7:0] gray_q, thr_q, thr_d, thr;
  logic dval_q, fval_q, dval_p_q, fval_p_q;
  logic [X_W-1:0] x_q, x_d, x_cur, ox_q, ox_d;
  logic [Y_W-1:0] ln_q, ln_d, ln_cur, oy_q, oy_d;
  logic pix_q, val_q, row_q, frm_q;
  logic [1:0] err_q, err_d, err_set;
  logic rise, fall, act_st, act, pix, line_ok, x_ok, valid, ink, dfall, row_end;
  assign rise    = fval_q & ~fval_p_q;
  assign fall    = ~fval_q & fval_p_q;
  assign act_st  = state_q == ACTIVE;
  // A pixel arriving with the very first FVAL-high sample belongs to the new frame.
  assign act     = fval_q & (act_st | (state_q == SYNC & rise));
  assign thr     = act_st ? thr_q : iThresh;
  assign x_cur   = act_st ? x_q : '0;
  assign ln_cur  = act_st ? ln_q : '0;
  assign line_ok = ln_cur < YLIM;
  assign x_ok    = x_cur < XLIM;
  assign pix     = act & dval_q;
  assign valid   = pix & line_ok & x_ok;
  assign ink     = INK_DARK ? (gray_q < thr) : (gray_q >= thr);
  assign dfall   = act_st & fval_p_q & dval_p_q & ~dval_q;
  assign row_end = dfall & line_ok;
  assign err_set = {pix & ~line_ok, pix & line_ok & ~x_ok};
  assign err_d   = (err_q & {2{~iErr_clr}}) | err_set;
  assign thr_d   = (state_q == SYNC & rise) ? iThresh : thr_q;
  assign x_d     = dfall ? '0 : (pix & x_ok) ? x_cur + 1'b1 : x_cur;
  assign ln_d    = row_end ? ln_cur + 1'b1 : ln_cur;
  assign ox_d    = valid ? x_cur : ox_q;
  assign oy_d    = valid ? ln_cur : oy_q;
  // IDLE watches the raw input so a frame already in progress at reset release is skipped.
  assign state_d = (state_q == IDLE) ? (iFVAL ? IDLE : SYNC) :
                   (state_q == SYNC) ? (rise ? ACTIVE : SYNC) :
                   (fall ? SYNC : ACTIVE);
  always_ff @(posedge iCLK or negedge iRST)
    if (!iRST) begin
      state_q  <= IDLE;
      gray_q   <= '0;
      dval_q   <= 1'b0;
      fval_q   <= 1'b0;
      dval_p_q <= 1'b0;
      fval_p_q <= 1'b0;
      thr_q    <= '0;
      x_q      <= '0;
      ln_q     <= '0;
      pix_q    <= 1'b0;
      val_q    <= 1'b0;
      ox_q     <= '0;
      oy_q     <= '0;
      row_q    <= 1'b0;
      frm_q    <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      gray_q   <= iGray;
      dval_q   <= iDVAL;
      fval_q   <= iFVAL;
      dval_p_q <= dval_q;
      fval_p_q <= fval_q;
      thr_q    <= thr_d;
      x_q      <= x_d;
      ln_q     <= ln_d;
      pix_q    <= valid & ink;
      val_q    <= valid;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      row_q    <= row_end;
      frm_q    <= act_st & fall;
      err_q    <= err_d;
    end
  assign oPixel     = pix_q;
  assign oPix_val   = val_q;
  assign oX         = ox_q;
  assign oY         = oy_q;
  assign oRow_end   = row_q;
  assign oFrame_end = frm_q;
  assign oErr       = err_q;
endmodule

// File: tb/tb_pixel_binarizer.sv
// tb_pixel_binarizer: directed frames on a 4x3 binarizer with hand-computed expectations.
module tb_pixel_binarizer;
  logic iCLK = 1'b0, iRST = 1'b0;
  logic [7:0] iGray = '0, iThresh = 8'd128;
  logic iDVAL = 1'b0, iFVAL = 1'b0, iErr_clr = 1'b0;
  logic oPixel, oPix_val, oRow_end, oFrame_end;
  logic [9:0] oX;
  logic [8:0] oY;
  logic [1:0] oErr;
  int n_cmp = 0, n_err = 0;
  int n_row = 0, n_frm = 0, n_both = 0, n_bad = 0;
  int px_log[$], x_log[$], y_log[$];
  always #5 iCLK = ~iCLK;
  pixel_binarizer #(.WIDTH(4), .HEIGHT(3), .INK_DARK(1'b1)) dut (
    .iCLK(iCLK), .iRST(iRST), .iGray(iGray), .iDVAL(iDVAL), .iFVAL(iFVAL),
    .iThresh(iThresh), .iErr_clr(iErr_clr), .oPixel(oPixel), .oPix_val(oPix_val),
    .oX(oX), .oY(oY), .oRow_end(oRow_end), .oFrame_end(oFrame_end), .oErr(oErr)
  );
  always @(negedge iCLK) begin
    if (oPix_val) begin
      px_log.push_back(int'(oPixel));
      x_log.push_back(int'(oX));
      y_log.push_back(int'(oY));
    end
    n_row += int'(oRow_end);
    n_frm += int'(oFrame_end);
    if (oRow_end && oFrame_end) n_both++;
    if (oRow_end && oPix_val) n_bad++;
  end
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask
  task automatic drive(input logic d, input logic f, input logic [7:0] g);
    iDVAL = d;
    iFVAL = f;
    iGray = g;
    tick();
  endtask
  task automatic clear_log();
    px_log.delete();
    x_log.delete();
    y_log.delete();
    n_row = 0;
    n_frm = 0;
    n_both = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'd0);
  endtask
  task automatic open_frame();
    idle(3);
    drive(1'b0, 1'b1, 8'd0);
    drive(1'b0, 1'b1, 8'd0);
  endtask
  task automatic line(input int n, input logic [7:0] g0, input logic [7:0] g1);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, (i % 2) ? g1 : g0);
    drive(1'b0, 1'b1, 8'd0);
    drive(1'b0, 1'b1, 8'd0);
  endtask
  initial begin
    repeat (3) @(posedge iCLK);
    #1;
    check("rst_val", int'(oPix_val), 0);
    check("rst_pixel", int'(oPixel), 0);
    check("rst_x", int'(oX), 0);
    check("rst_y", int'(oY), 0);
    check("rst_row", int'(oRow_end), 0);
    check("rst_frm", int'(oFrame_end), 0);
    check("rst_err", int'(oErr), 0);
    iRST = 1'b1;
    // Scenario 1: 4x3 frame, alternating 0/255 against 128
    clear_log();
    open_frame();
    iDVAL = 1'b1; iGray = 8'd0; tick();
    check("lat_1cyc", int'(oPix_val), 0);
    iGray = 8'd255; tick();
    check("lat_2cyc_val", int'(oPix_val), 1);
    check("lat_2cyc_pix", int'(oPixel), 1);
    iGray = 8'd0; tick();
    iGray = 8'd255; tick();
    drive(1'b0, 1'b1, 8'd0);
    check("row_end_early", int'(oRow_end), 0);
    drive(1'b0, 1'b1, 8'd0);
    check("row_end_2cyc", int'(oRow_end), 1);
    line(4, 8'd0, 8'd255);
    line(4, 8'd0, 8'd255);
    drive(1'b0, 1'b0, 8'd0);
    check("frm_early", int'(oFrame_end), 0);
    drive(1'b0, 1'b0, 8'd0);
    check("frm_2cyc", int'(oFrame_end), 1);
    idle(2);
    check("s1_count", px_log.size(), 12);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("s1_pix%0d", i), px_log[i], (i % 2 == 0) ? 1 : 0);
      check($sformatf("s1_x%0d", i), x_log[i], i % 4);
      check($sformatf("s1_y%0d", i), y_log[i], i / 4);
    end
    check("s1_rows", n_row, 3);
    check("s1_frames", n_frm, 1);
    check("s1_both", n_both, 0);
    // Scenario 2: reset mid-frame, released with FVAL still high
    open_frame();
    drive(1'b1, 1'b1, 8'd0);
    drive(1'b1, 1'b1, 8'd0);
    drive(1'b1, 1'b1, 8'd0);
    iRST = 1'b0;
    #1;
    check("rst_async_val", int'(oPix_val), 0);
    check("rst_async_x", int'(oX), 0);
    clear_log();
    repeat (3) tick();
    iRST = 1'b1;
    drive(1'b1, 1'b1, 8'd0);
    drive(1'b1, 1'b1, 8'd0);
    drive(1'b0, 1'b1, 8'd0);
    drive(1'b0, 1'b1, 8'd0);
    line(4, 8'd0, 8'd0);
    line(4, 8'd0, 8'd0);
    check("s2_hold_val", px_log.size(), 0);
    check("s2_hold_row", n_row, 0);
    check("s2_hold_frm", n_frm, 0);
    open_frame();
    line(4, 8'd0, 8'd0);
    idle(4);
    check("s2_resume_val", px_log.size(), 4);
    check("s2_resume_row", n_row, 1);
    check("s2_resume_frm", n_frm, 1);
    // Scenario 3: 6-pixel line on a 4-wide frame
    clear_log();
    check("s3_err_before", int'(oErr), 0);
    open_frame();
    line(6, 8'd0, 8'd0);
    check("s3_val", px_log.size(), 4);
    check("s3_xsat", x_log[3], 3);
    check("s3_err_set", int'(oErr), 1);
    idle(4);
    check("s3_err_sticky", int'(oErr), 1);
    iErr_clr = 1'b1; tick(); iErr_clr = 1'b0;
    check("s3_err_clr", int'(oErr), 0);
    // Scenario 4: threshold change only takes effect on the next frame
    clear_log();
    open_frame();
    line(4, 8'd50, 8'd50);
    iThresh = 8'd10;
    line(4, 8'd50, 8'd50);
    idle(4);
    check("s4_a_val", px_log.size(), 8);
    check("s4_a_ink", px_log.sum(), 8);
    clear_log();
    open_frame();
    line(4, 8'd10, 8'd9);
    idle(4);
    check("s4_b_val", px_log.size(), 4);
    check("s4_b_eq_thr", px_log[0], 0);
    check("s4_b_below", px_log[1], 1);
    check("s4_b_eq_thr2", px_log[2], 0);
    check("s4_b_below2", px_log[3], 1);
    iThresh = 8'd128;
    // Scenario 5: FVAL drops while DVAL is high in row 1
    clear_log();
    open_frame();
    line(4, 8'd0, 8'd255);
    drive(1'b1, 1'b1, 8'd0);
    drive(1'b1, 1'b1, 8'd255);
    drive(1'b0, 1'b0, 8'd0);
    idle(4);
    check("s5_val", px_log.size(), 6);
    check("s5_rows", n_row, 2);
    check("s5_frames", n_frm, 1);
    check("s5_together", n_both, 1);
    clear_log();
    open_frame();
    line(4, 8'd0, 8'd255);
    idle(4);
    check("s5_next_val", px_log.size(), 4);
    check("s5_next_y", y_log[0], 0);
    check("s5_next_x", x_log[0], 0);
    // Scenario 6: four lines on a 3-high frame
    clear_log();
    open_frame();
    repeat (4) line(4, 8'd0, 8'd255);
    idle(4);
    check("s6_val", px_log.size(), 12);
    check("s6_rows", n_row, 3);
    check("s6_last_y", y_log[11], 2);
    check("s6_err", int'(oErr), 2);
    iErr_clr = 1'b1; tick(); iErr_clr = 1'b0;
    // DVAL without FVAL is ignored
    clear_log();
    idle(2);
    repeat (4) drive(1'b1, 1'b0, 8'd0);
    idle(4);
    check("s7_val", px_log.size(), 0);
    check("s7_rows", n_row, 0);
    check("s7_frames", n_frm, 0);
    check("s7_err", int'(oErr), 0);
    check("row_end_with_val", n_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
